// File: rtl/fifo_r_ctrl_if.sv
// Signal bundle between the FIFO read controller and its neighbours.
// The write pointer and read request come in; the read pointer, strobes and flags go out.
interface fifo_r_ctrl_if #(
    parameter int DEEP = 8
);
    logic [DEEP:0] wr_addr;
    logic          rd_en;
    logic [DEEP:0] rd_addr;
    logic          pop;
    logic          dout_valid;
    logic          empty;
    logic          full;
    logic [DEEP:0] count;

    modport master (
        output wr_addr, rd_en,
        input  rd_addr, pop, dout_valid, empty, full, count
    );

    modport slave (
        input  wr_addr, rd_en,
        output rd_addr, pop, dout_valid, empty, full, count
    );
endinterface

// File: rtl/fifo_r_ctrl.sv
// Read-side control FSM for the synchronous FIFO.
// It owns the read pointer and derives empty/full/count from the write controller's pointer.
module fifo_r_ctrl #(
    parameter int DEEP = 8
) (
    input  logic         clk,
    input  logic         arst,
    fifo_r_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMPTY = 2'd1,
        POP   = 2'd2
    } state_e;

    state_e        state_q;
    state_e        state_d;
    logic [DEEP:0] rd_addr_q;
    logic [DEEP:0] rd_addr_d;
    logic [DEEP:0] rd_addr_la_s;
    logic          dout_valid_q;
    logic          pop_s;
    logic          empty_la_s;

    assign pop_s = (state_q == POP);

    // Next-state logic: the emptiness test uses the pointer as it will be after
    // this cycle's pop, so POP is never entered or held on an empty slot.
    always_comb begin
        rd_addr_la_s = rd_addr_q + {{DEEP{1'b0}}, pop_s};
        empty_la_s   = (bus.wr_addr == rd_addr_la_s);
        rd_addr_d    = rd_addr_la_s;
        state_d      = IDLE;
        case (state_q)
            IDLE, EMPTY, POP: begin
                if (empty_la_s) begin
                    state_d = EMPTY;
                end else if (bus.rd_en) begin
                    state_d = POP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, read pointer and read-data-valid registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= IDLE;
            rd_addr_q    <= {(DEEP+1){1'b0}};
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            dout_valid_q <= pop_s;
        end
    end

    // Equal low bits: the wrap bit tells full from empty.
    assign bus.empty      = (bus.wr_addr == rd_addr_q);
    assign bus.full       = (bus.wr_addr[DEEP] != rd_addr_q[DEEP]) &&
                            (bus.wr_addr[DEEP-1:0] == rd_addr_q[DEEP-1:0]);
    assign bus.count      = bus.wr_addr - rd_addr_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.pop        = pop_s;
    assign bus.dout_valid = dout_valid_q;
endmodule

// File: tb/tb_fifo_r_ctrl.sv
// Directed bench for fifo_r_ctrl with DEEP=3 (4-bit pointers, 8 entries).
module tb_fifo_r_ctrl;
    localparam int DEEP = 3;

    logic clk;
    logic arst;
    int   vec_cnt;
    int   err_cnt;
    logic [3:0] exp_rd;
    logic [3:0] exp_wr;
    int   pop_seen;

    fifo_r_ctrl_if #(.DEEP(DEEP)) bus ();

    fifo_r_ctrl #(.DEEP(DEEP)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push();
        exp_wr      = exp_wr + 4'd1;
        bus.wr_addr = exp_wr;
        #1;
    endtask

    initial begin
        vec_cnt     = 0;
        err_cnt     = 0;
        arst        = 1'b1;
        bus.wr_addr = 4'd0;
        bus.rd_en   = 1'b0;
        exp_wr      = 4'd0;
        #23;
        chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_pop", 32'(bus.pop), 32'd0);
        chk("rst_dv", 32'(bus.dout_valid), 32'd0);
        arst      = 1'b0;
        bus.rd_en = 1'b1;
        tick();
        chk("blk_state", 32'(dut.state_q), 32'd1);
        chk("blk_pop", 32'(bus.pop), 32'd0);

        // single push, read request held
        push();
        chk("one_empty", 32'(bus.empty), 32'd0);
        chk("one_count", 32'(bus.count), 32'd1);
        tick();
        chk("one_pop", 32'(bus.pop), 32'd1);
        chk("one_rd0", 32'(bus.rd_addr), 32'd0);
        chk("one_dv0", 32'(bus.dout_valid), 32'd0);
        tick();
        chk("one_pop_end", 32'(bus.pop), 32'd0);
        chk("one_rd1", 32'(bus.rd_addr), 32'd1);
        chk("one_dv1", 32'(bus.dout_valid), 32'd1);
        chk("one_empty_back", 32'(bus.empty), 32'd1);
        chk("one_state", 32'(dut.state_q), 32'd1);
        tick();
        chk("one_dv_end", 32'(bus.dout_valid), 32'd0);

        // fill to full with no read request, then drain
        bus.rd_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push();
            tick();
            chk("fill_pop", 32'(bus.pop), 32'd0);
        end
        chk("fill_count", 32'(bus.count), 32'd8);
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_empty", 32'(bus.empty), 32'd0);
        bus.rd_en = 1'b1;
        pop_seen  = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (bus.pop === 1'b1) pop_seen++;
            if (i == 0) chk("drain_full_held", 32'(bus.full), 32'd1);
            if (i == 1) chk("drain_full_clr", 32'(bus.full), 32'd0);
            if (i == 1) chk("drain_count7", 32'(bus.count), 32'd7);
            if (i < 8) chk("drain_pop_run", 32'(bus.pop), 32'd1);
        end
        chk("drain_pops", 32'(pop_seen), 32'd8);
        chk("drain_count", 32'(bus.count), 32'd0);
        chk("drain_rd", 32'(bus.rd_addr), 32'd9);
        chk("drain_empty", 32'(bus.empty), 32'd1);

        // wrap-around: one push per cycle with reads held, 20 pushes total
        exp_rd = 4'd9;
        push();
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("wrap_rd", 32'(bus.rd_addr), 32'(exp_rd));
            chk("wrap_count", 32'(bus.count), 32'd1);
            chk("wrap_full", 32'(bus.full), 32'd0);
            chk("wrap_empty", 32'(bus.empty), 32'd0);
            chk("wrap_pop", 32'(bus.pop), 32'd1);
            exp_rd = exp_rd + 4'd1;
            if (k < 19) push();
        end
        tick();
        chk("wrap_end_rd", 32'(bus.rd_addr), 32'd13);
        chk("wrap_end_empty", 32'(bus.empty), 32'd1);
        chk("wrap_end_pop", 32'(bus.pop), 32'd0);

        // steady push+pop at count 4
        bus.rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push();
            tick();
        end
        chk("steady_count0", 32'(bus.count), 32'd4);
        chk("steady_state_idle", 32'(dut.state_q), 32'd0);
        bus.rd_en = 1'b1;
        tick();
        chk("steady_pop0", 32'(bus.pop), 32'd1);
        for (int i = 0; i < 10; i++) begin
            push();
            tick();
            chk("steady_count", 32'(bus.count), 32'd4);
            chk("steady_pop", 32'(bus.pop), 32'd1);
        end

        // asynchronous reset mid-drain at count 5
        push();
        chk("arst_pre_count", 32'(bus.count), 32'd5);
        chk("arst_pre_dv", 32'(bus.dout_valid), 32'd1);
        #1;
        arst        = 1'b1;
        exp_wr      = 4'd0;
        bus.wr_addr = 4'd0;
        #1;
        chk("arst_pop", 32'(bus.pop), 32'd0);
        chk("arst_dv", 32'(bus.dout_valid), 32'd0);
        chk("arst_rd", 32'(bus.rd_addr), 32'd0);
        chk("arst_count", 32'(bus.count), 32'd0);
        tick();
        tick();
        chk("arst_hold_rd", 32'(bus.rd_addr), 32'd0);
        arst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_pop", 32'(bus.pop), 32'd0);
            chk("post_rst_rd", 32'(bus.rd_addr), 32'd0);
        end
        push();
        tick();
        chk("post_rst_newpop", 32'(bus.pop), 32'd1);
        tick();
        chk("post_rst_rd1", 32'(bus.rd_addr), 32'd1);
        chk("post_rst_dv", 32'(bus.dout_valid), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
